// File: rtl/mem_ctrl.sv
// Single-port memory controller: accepts CPU read/write requests and sequences
// them onto a synchronous-read memory. Optional write read-back via MEM_CTRL_READBACK_EN.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        txn_count
);

`ifdef MEM_CTRL_READBACK_EN
  typedef enum logic [2:0] {
    StIdle, StWrite, StRdIssue, StRdCap, StResp, StRbIssue, StRbCap
  } state_e;
  logic err_q;
  assign rsp_err = err_q;
`else
  typedef enum logic [2:0] {
    StIdle, StWrite, StRdIssue, StRdCap, StResp
  } state_e;
  assign rsp_err = 1'b0;
`endif

  state_e state_q;

  assign req_ready = (state_q == StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      txn_count <= 8'd0;
`ifdef MEM_CTRL_READBACK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // Request fields are captured here so later req_* changes cannot leak in.
          if (req_valid) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            if (req_we) begin
              mem_we  <= 1'b1;
              state_q <= StWrite;
            end else begin
              state_q <= StRdIssue;
            end
          end
        end
        StWrite: begin
          mem_we <= 1'b0;
`ifdef MEM_CTRL_READBACK_EN
          state_q <= StRbIssue;
`else
          rsp_valid <= 1'b1;
          state_q   <= StResp;
`endif
        end
        StRdIssue: state_q <= StRdCap;
        StRdCap: begin
          rsp_rdata <= mem_rdata;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
`ifdef MEM_CTRL_READBACK_EN
        StRbIssue: state_q <= StRbCap;
        StRbCap: begin
          rsp_rdata <= mem_rdata;
          err_q     <= (mem_rdata != mem_wdata);
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
`endif
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_count <= txn_count + 8'd1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
